operand_issue_stage: RTL and testbench

OPERAND_ISSUE_STAGE -- requirements
Module: operand_issue_stage

---
 rtl/operand_issue_stage.sv | 175 +++++++++++++++++
 tb/tb_operand_issue_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue_stage.sv
// Operand issue stage: resolves rs/rt through EX/MEM/WB forwarding, builds the B operand,
// detects load-use hazards and registers the issued instruction for the execute stage.
module operand_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    // Decode-side instruction
    input  logic              in_valid,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [15:0]       in_imm,
    input  logic              in_use_imm,
    input  logic              in_sign_ext,
    input  logic [5:0]        in_operation,
    input  logic [2:0]        in_alu_code,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    // Result of the instruction currently presented on the outputs
    input  logic [DATA_W-1:0] ex_result,
    // Later-stage writeback sources
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    // Issued instruction
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [5:0]        operation,
    output logic [2:0]        alu_code,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic [DATA_W-1:0] out_store_data,
    output logic              hazard_stall
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [5:0]        operation_q, operation_d;
    logic [2:0]        alu_code_q, alu_code_d;
    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [DATA_W-1:0] imm_ext;
    logic              ex_fwd_ok;

    // A load in EX has no result yet, so it never forwards; that case is the hazard instead.
    assign ex_fwd_ok = valid_q & reg_write_q & ~mem_read_q & (rd_q != '0);

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_ok,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_data,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic [DATA_W-1:0] m_data,
        input logic              w_we,
        input logic [REG_AW-1:0] w_rd,
        input logic [DATA_W-1:0] w_data
    );
        logic [DATA_W-1:0] res;
        res = rf_data;
        if (ex_ok && (ex_rd == src)) begin
            res = ex_data;
        end else if (m_we && (m_rd == src) && (m_rd != '0)) begin
            res = m_data;
        end else if (w_we && (w_rd == src) && (w_rd != '0)) begin
            res = w_data;
        end
        return res;
    endfunction

    always_comb begin
        rs_fwd = fwd_sel(in_rs, in_rs_data, ex_fwd_ok, rd_q, ex_result,
                         mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data);
        rt_fwd = fwd_sel(in_rt, in_rt_data, ex_fwd_ok, rd_q, ex_result,
                         mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data);
    end

    always_comb begin
        if (in_sign_ext) begin
            imm_ext = {{(DATA_W-16){in_imm[15]}}, in_imm};
        end else begin
            imm_ext = {{(DATA_W-16){1'b0}}, in_imm};
        end
    end

    assign hazard_stall = valid_q & mem_read_q & in_valid & (rd_q != '0) &
                          ((rd_q == in_rs) | ((rd_q == in_rt) & ~in_use_imm));

    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        operation_d  = operation_q;
        alu_code_d   = alu_code_q;
        valid_d      = valid_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        store_data_d = store_data_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (hazard_stall) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else begin
            a_d          = rs_fwd;
            b_d          = in_use_imm ? imm_ext : rt_fwd;
            operation_d  = in_operation;
            alu_code_d   = in_alu_code;
            valid_d      = in_valid;
            rd_d         = in_rd;
            reg_write_d  = in_valid & in_reg_write;
            mem_read_d   = in_valid & in_mem_read;
            store_data_d = rt_fwd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            operation_q  <= '0;
            alu_code_q   <= '0;
            valid_q      <= 1'b0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            store_data_q <= '0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            operation_q  <= operation_d;
            alu_code_q   <= alu_code_d;
            valid_q      <= valid_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            store_data_q <= store_data_d;
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign operation      = operation_q;
    assign alu_code       = alu_code_q;
    assign out_valid      = valid_q;
    assign out_rd         = rd_q;
    assign out_reg_write  = reg_write_q;
    assign out_mem_read   = mem_read_q;
    assign out_store_data = store_data_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Randomised and directed bench for operand_issue_stage against a behavioural pipeline model.
module tb_operand_issue_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset, stall, flush;
    logic          in_valid, in_use_imm, in_sign_ext, in_reg_write, in_mem_read;
    logic [AW-1:0] in_rs, in_rt, in_rd, mem_rd, wb_rd;
    logic [DW-1:0] in_rs_data, in_rt_data, ex_result, mem_data, wb_data;
    logic [15:0]   in_imm;
    logic [5:0]    in_operation;
    logic [2:0]    in_alu_code;
    logic          mem_reg_write, wb_reg_write;
    logic [DW-1:0] a, b, out_store_data;
    logic [5:0]    operation;
    logic [2:0]    alu_code;
    logic          out_valid, out_reg_write, out_mem_read, hazard_stall;
    logic [AW-1:0] out_rd;

    int checks = 0;
    int failures = 0;

    // Model of the presented instruction; m_dc marks data fields as don't-care.
    logic [DW-1:0] m_a, m_b, m_sd;
    logic [5:0]    m_op;
    logic [2:0]    m_alu;
    logic [AW-1:0] m_rd;
    logic          m_valid, m_rw, m_mr, m_dc;

    always #5 clk = ~clk;

    operand_issue_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext), .in_operation(in_operation),
        .in_alu_code(in_alu_code), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .ex_result(ex_result), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_data(mem_data), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .a(a), .b(b), .operation(operation), .alu_code(alu_code), .out_valid(out_valid),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_store_data(out_store_data), .hazard_stall(hazard_stall)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] r, input logic [DW-1:0] d);
        if (r == 0) return d;
        if (m_valid && m_rw && !m_mr && m_rd == r) return ex_result;
        if (mem_reg_write && mem_rd == r) return mem_data;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return d;
    endfunction

    function automatic logic model_hazard();
        return m_valid && m_mr && in_valid && m_rd != 0 &&
               (m_rd == in_rs || (m_rd == in_rt && !in_use_imm));
    endfunction

    task automatic compare();
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, model_hazard()});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, m_rw});
        chk("out_mem_read", {31'd0, out_mem_read}, {31'd0, m_mr});
        if (!m_dc) begin
            chk("a", a, m_a);
            chk("b", b, m_b);
            chk("store_data", out_store_data, m_sd);
            chk("operation", {26'd0, operation}, {26'd0, m_op});
            chk("alu_code", {29'd0, alu_code}, {29'd0, m_alu});
            chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        end
    endtask

    // Inputs are stable: check, advance the model across the edge, return at negedge.
    task automatic cycle();
        logic [DW-1:0] n_a, n_b, n_sd, ext;
        logic          hz;
        #1 compare();
        hz   = model_hazard();
        ext  = in_sign_ext ? DW'($signed(in_imm)) : DW'(in_imm);
        n_a  = model_fwd(in_rs, in_rs_data);
        n_sd = model_fwd(in_rt, in_rt_data);
        n_b  = in_use_imm ? ext : n_sd;
        @(posedge clk);
        if (reset) begin
            m_a = 0; m_b = 0; m_sd = 0; m_op = 0; m_alu = 0; m_rd = 0;
            m_valid = 0; m_rw = 0; m_mr = 0; m_dc = 0;
        end else if (flush || (!stall && hz)) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_dc = 1;
        end else if (!stall) begin
            m_a = n_a; m_b = n_b; m_sd = n_sd; m_op = in_operation; m_alu = in_alu_code;
            m_rd = in_rd; m_valid = in_valid; m_rw = in_valid & in_reg_write;
            m_mr = in_valid & in_mem_read; m_dc = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; flush = 0;
        in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_rs_data = 0; in_rt_data = 0;
        in_imm = 0; in_use_imm = 0; in_sign_ext = 0; in_operation = 0; in_alu_code = 0;
        in_reg_write = 0; in_mem_read = 0; ex_result = 0;
        mem_reg_write = 0; mem_rd = 0; mem_data = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic randomize_inputs();
        reset = ($urandom_range(0, 39) == 0);
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 9) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
        in_rs = AW'($urandom_range(0, 7)); in_rt = AW'($urandom_range(0, 7));
        in_rd = AW'($urandom_range(0, 7));
        in_rs_data = $urandom; in_rt_data = $urandom; in_imm = 16'($urandom);
        in_use_imm = $urandom_range(0, 1) == 1; in_sign_ext = $urandom_range(0, 1) == 1;
        in_operation = 6'($urandom); in_alu_code = 3'($urandom);
        in_reg_write = ($urandom_range(0, 3) != 0); in_mem_read = ($urandom_range(0, 2) == 0);
        ex_result = $urandom;
        mem_reg_write = $urandom_range(0, 1) == 1; mem_rd = AW'($urandom_range(0, 7));
        mem_data = $urandom;
        wb_reg_write = $urandom_range(0, 1) == 1; wb_rd = AW'($urandom_range(0, 7));
        wb_data = $urandom;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        m_a = 0; m_b = 0; m_sd = 0; m_op = 0; m_alu = 0; m_rd = 0;
        m_valid = 0; m_rw = 0; m_mr = 0; m_dc = 0;
        @(posedge clk); @(negedge clk);
        cycle();
        // Reset state
        chk("rst a", a, 0); chk("rst b", b, 0); chk("rst valid", {31'd0, out_valid}, 0);
        chk("rst operation", {26'd0, operation}, 0);
        reset = 0;

        // Basic capture, no forwarding
        in_valid = 1; in_rs = 3; in_rs_data = 5; in_rt = 4; in_rt_data = 7; in_rd = 9;
        in_reg_write = 1;
        cycle();
        chk("basic a", a, 32'd5); chk("basic b", b, 32'd7);
        chk("basic valid", {31'd0, out_valid}, 32'd1);

        // EX beats MEM
        idle_inputs(); in_valid = 1; in_rd = 3; in_reg_write = 1;
        cycle();
        in_rd = 1; in_rs = 3; in_rs_data = 32'h1; ex_result = 32'h10;
        mem_reg_write = 1; mem_rd = 3; mem_data = 32'h20;
        cycle();
        chk("ex over mem", a, 32'h10);

        // Load-use hazard then forward from MEM
        idle_inputs(); in_valid = 1; in_rd = 8; in_reg_write = 1; in_mem_read = 1;
        cycle();
        in_rd = 2; in_mem_read = 0; in_rs = 8; in_rs_data = 32'h3;
        #1 chk("hazard literal", {31'd0, hazard_stall}, 32'd1);
        cycle();
        chk("bubble valid", {31'd0, out_valid}, 0);
        mem_reg_write = 1; mem_rd = 8; mem_data = 32'h55;
        cycle();
        chk("load fwd a", a, 32'h55);

        // Immediate extension
        idle_inputs(); in_valid = 1; in_use_imm = 1; in_imm = 16'hFFFF; in_sign_ext = 1;
        cycle();
        chk("imm sext", b, 32'hFFFF_FFFF);
        in_sign_ext = 0;
        cycle();
        chk("imm zext", b, 32'h0000_FFFF);

        // r0 never forwarded
        idle_inputs(); in_valid = 1; mem_reg_write = 1; mem_rd = 0; mem_data = 32'h99;
        cycle();
        chk("r0 a", a, 0);

        // Stall hold, flush, reset under stall
        idle_inputs(); in_valid = 1; in_rs_data = 32'hABCD; in_reg_write = 1; in_rd = 5;
        cycle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_rs_data = $urandom; in_valid = i[0];
            cycle();
            chk("stall hold a", a, 32'hABCD);
        end
        flush = 1;
        cycle();
        chk("flush valid", {31'd0, out_valid}, 0);
        flush = 0; reset = 1;
        cycle();
        chk("rst-stall a", a, 0); chk("rst-stall rd", {27'd0, out_rd}, 0);
        idle_inputs();
        cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            randomize_inputs();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
